// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared constants and types for the main-memory fill responder.
package mem_resp_pkg;

   // Cache block geometry used by the burst path
   localparam int BLOCK_WORDS = 8;
   localparam int WORD_OFF_W  = 3;

   // Default timing
   localparam int DEF_LATENCY   = 4;
   localparam int DEF_WR_CYCLES = 4;

   // Storage word width
   localparam int MEM_DATA_W = 16;

   typedef logic [MEM_DATA_W-1:0] mem_word_t;

   // One stage of the read-return delay line
   typedef struct packed {
      logic      valid;
      mem_word_t data;
   } rd_slot_t;

   // Burst sequencer states
   typedef enum logic {
      IDLE,
      BURST
   } burst_state_t;

endpackage

// File: rtl/mem_delay_line.sv
// mem_delay_line: LATENCY-deep valid/data shift register for read returns.
// Stage 0 loads on the acceptance edge; the last stage drives the return port.
module mem_delay_line
   import mem_resp_pkg::*;
#(
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic     clk,
   input  logic     rst,      // asynchronous, active-low
   input  rd_slot_t slotIn,
   output rd_slot_t slotOut
);

   rd_slot_t slots [LATENCY];

   // Shift every slot forward one stage per cycle; reset discards reads in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LATENCY; i++) slots[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments make every stage read its neighbour's old
         // value, so the loop order does not matter and no stage is skipped.
         slots[0] <= slotIn;
         for (int i = 1; i < LATENCY; i++) slots[i] <= slots[i-1];
      end
   end

   assign slotOut = slots[LATENCY-1];

endmodule

// File: rtl/mem_fill_responder.sv
// mem_fill_responder: memory end of the cache-fill interface.
// Pipelined word reads returned LATENCY cycles after acceptance, write-through
// stores with WR_CYCLES of write recovery signalled on memory_busy.
// Optional feature: define MEMRESP_BURST_EN to turn every accepted read into an
// 8-word critical-word-first block burst.
module mem_fill_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = MEM_DATA_W,   // must equal the package word width
   parameter int LATENCY   = DEF_LATENCY,
   parameter int WR_CYCLES = DEF_WR_CYCLES,
   parameter int MEM_WORDS = 65536
) (
   input  logic              clk,
   input  logic              rst,          // asynchronous, active-low
   input  logic              enable,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              memory_busy
);

   localparam int IDX_W    = $clog2(MEM_WORDS);
   localparam int WRD_W    = ADDR_W - 1;
   localparam int WR_CNT_W = 4;

   logic [DATA_W-1:0]   mem [MEM_WORDS];
   logic [WR_CNT_W-1:0] wrCnt;
   logic                wrBusy;
   logic                burstBusy;
   logic                accept;
   logic                wrAccept;
   logic                rdAccept;
   logic                issueValid;
   logic [WRD_W-1:0]    issueWord;
   rd_slot_t            issueSlot;
   rd_slot_t            retSlot;

   // Busy depends only on registered state, never on enable
   assign wrBusy      = (wrCnt != '0);
   assign memory_busy = wrBusy | burstBusy;
   assign accept      = enable & ~memory_busy;
   assign wrAccept    = accept & wr;
   assign rdAccept    = accept & ~wr;

   // Storage write port; the word index wraps modulo MEM_WORDS
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset - its contents survive rst and it maps onto RAM.
      if (wrAccept) mem[IDX_W'(addr >> 1)] <= data_in;
   end

   // Write-recovery counter: loaded on a write, counts down to idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          wrCnt <= '0;
      else if (wrAccept) wrCnt <= WR_CNT_W'(WR_CYCLES - 1);
      else if (wrBusy)   wrCnt <= wrCnt - WR_CNT_W'(1);
   end

   // Sample storage into stage 1 of the return path; idle slots carry zero data
   always_comb begin
      // NOTE: assign a default first so every path drives issueSlot and no latch forms.
      issueSlot = '0;
      if (issueValid) begin
         issueSlot.valid = 1'b1;
         issueSlot.data  = mem[IDX_W'(issueWord)];
      end
   end

`ifdef MEMRESP_BURST_EN
   burst_state_t          state;
   burst_state_t          stateNext;
   logic [WORD_OFF_W-1:0] burstCnt;    // offset of the next word from the critical word
   logic [WORD_OFF_W-1:0] burstOff;    // critical word offset within the block
   logic [WRD_W-WORD_OFF_W-1:0] burstBlock;

   assign burstBusy = (state == BURST);

   // State register plus burst bookkeeping captured at acceptance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         burstCnt   <= '0;
         burstOff   <= '0;
         burstBlock <= '0;
      end else begin
         state <= stateNext;
         if (state == IDLE) begin
            if (rdAccept) begin
               burstCnt   <= WORD_OFF_W'(1);
               burstOff   <= addr[WORD_OFF_W:1];
               burstBlock <= addr[ADDR_W-1:WORD_OFF_W+1];
            end
         end else begin
            burstCnt <= burstCnt + WORD_OFF_W'(1);
         end
      end
   end

   // Next state: a read starts a burst, the eighth issued word ends it
   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (rdAccept) stateNext = BURST;
         BURST:   if (burstCnt == WORD_OFF_W'(BLOCK_WORDS - 1)) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Issue the critical word at acceptance, then the rest of the block wrapping mod 8
   always_comb begin
      issueValid = rdAccept;
      issueWord  = WRD_W'(addr >> 1);
      if (state == BURST) begin
         issueValid = 1'b1;
         issueWord  = {burstBlock, burstOff + burstCnt};
      end
   end
`else
   assign burstBusy  = 1'b0;
   assign issueValid = rdAccept;
   assign issueWord  = WRD_W'(addr >> 1);
`endif

   mem_delay_line #(
      .LATENCY (LATENCY)
   ) u_ret_line (
      .clk     (clk),
      .rst     (rst),
      .slotIn  (issueSlot),
      .slotOut (retSlot)
   );

   assign data_valid = retSlot.valid;
   assign data_out   = retSlot.data;

endmodule

// File: doc/mem_fill_responder.md
Name: mem_fill_responder

Overview:
- Multi-cycle main-memory responder: the memory end of the cache-fill interface.
- Serves word reads issued by the cache fill FSM and returns data a fixed LATENCY cycles later with data_valid.
- Serves single-word write-through stores.
- Drives memory_busy back to the requester during write recovery (and during bursts when enabled).

Parameters:
- ADDR_W, 16: byte address width; word index = addr[ADDR_W-1:1].
- DATA_W, 16: word width.
- LATENCY, 4: cycles from read acceptance edge to data_valid (legal range 2..8).
- WR_CYCLES, 4: total cycles a write occupies the memory, including the acceptance cycle (legal range 1..8).
- MEM_WORDS, 65536: storage depth in words.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset.
- enable, input, 1: request valid this cycle.
- wr, input, 1: 1 = write, 0 = read; qualified by enable.
- addr, input, ADDR_W: byte address; bit 0 is ignored.
- data_in, input, DATA_W: write data.
- data_out, output, DATA_W: read data; meaningful only while data_valid = 1.
- data_valid, output, 1: read data returned this cycle.
- memory_busy, output, 1: new requests are ignored this cycle.

Behaviour:
- Reset (rst low, async):
  - data_out = 0, data_valid = 0, memory_busy = 0.
  - Read pipeline flushed; write-recovery counter = 0.
  - Storage contents are not reset.
  - Reads in flight when reset is asserted are discarded; no data_valid is produced for them after reset.
- Acceptance: a request is accepted on a rising edge where enable & ~memory_busy.
  - A request presented while memory_busy = 1 is dropped; the requester must hold it until accepted.
- Read:
  - Storage is sampled at the acceptance edge into stage 1 of a LATENCY-deep valid/data delay line.
  - data_valid and data_out assert exactly LATENCY cycles after acceptance, for one cycle per read.
  - Fully pipelined: one read accepted per cycle; back-to-back reads return back-to-back.
- Write:
  - Storage is updated at the acceptance edge.
  - memory_busy is then held high for the next WR_CYCLES-1 cycles, via a counter loaded with WR_CYCLES-1 and decremented to 0.
  - Reads already in flight continue to drain during busy.
- Ordering: reads sample at acceptance, so a read accepted after a write to the same word returns the new data. No other hazards exist.
- Boundaries:
  - WR_CYCLES = 1: memory_busy never asserts.
  - Address wraps modulo MEM_WORDS.
  - No separate idle state is needed: memory_busy is a pure function of the counter (and, when enabled, the burst state), with no combinational path from enable.

Optional Feature:
- Macro: MEMRESP_BURST_EN.
- Defined:
  - A single accepted read launches an 8-word burst covering the block containing addr (block = addr[ADDR_W-1:4]).
  - Critical word first: word order starts at addr[3:1] and wraps modulo 8 within the block.
  - Burst states: IDLE -> BURST. A 3-bit counter issues one word per cycle into the delay line.
  - memory_busy is high for the 7 cycles after acceptance.
  - Data returns as 8 consecutive data_valid cycles, starting LATENCY cycles after acceptance.
  - Writes are unaffected.
- Undefined: one word per read request; the burst FSM and counter are not built.

Decomposition:
- Package mem_resp_pkg holds:
  - BLOCK_WORDS = 8 and WORD_OFF_W = 3.
  - Default LATENCY and WR_CYCLES.
  - Typedef mem_word_t (DATA_W).
  - Typedef rd_slot_t (valid bit + mem_word_t).
- One sub-module: mem_delay_line.
  - Parameterised by LATENCY.
  - Async active-low clear of all slots.
  - Instantiated once for the read return path.

Test Plan:
- Reset, then preload word 0x0010 = 0xBEEF. Read addr 0x0020 at cycle 0 -> data_valid = 1 with data_out = 0xBEEF at cycle 4 only.
- Reads to addr 0x0000, 0x0002, 0x0004 on cycles 0–2 -> three consecutive data_valid cycles 4–6, returning mem[0], mem[1], mem[2] in order.
- Write 0x1234 to addr 0x0040 at cycle 0 -> memory_busy high for cycles 1–3. A read held from cycle 1 is accepted at cycle 4 and returns 0x1234 at cycle 8.
- Read accepted at cycle 0, rst pulsed low at cycle 2 -> data_valid stays 0 through cycle 6; data_out = 0 after reset.
- Request held while memory_busy = 1 -> no data_valid and no storage change until the cycle memory_busy falls.
- MEMRESP_BURST_EN: read addr 0x013A (block 0x13, word 5) -> data_valid cycles 4–11 return words 5,6,7,0,1,2,3,4 of block 0x13; memory_busy high for cycles 1–7.
